// File: rtl/seg_scan_ctrl_if.sv
// Host write port of seg_scan_ctrl: request/address/data from the host, one-cycle ack back.
interface seg_scan_ctrl_if;
    logic       wr_req;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic       wr_ack;

    modport master (output wr_req, wr_addr, wr_data, input wr_ack);
    modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with PWM brightness and host-writable digit buffer.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl #(
    parameter int NDIG        = 6,
    parameter int DWELL_UNIT  = 12,
    parameter int BLINK_SLOTS = 96
) (
    input  logic                clk_out100,
    input  logic                nRST,
    seg_scan_ctrl_if.slave      wr,
    input  logic [2:0]          bright,
    input  logic                blank,
`ifdef SEG_BLINK_EN
    input  logic [NDIG-1:0]     blink_mask,
`endif
    output logic [7:0]          seg,
    output logic [NDIG-1:0]     digit_sel
);

    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(8 * DWELL_UNIT);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    if (NDIG < 2 || NDIG > 8 || DWELL_UNIT < 1 || BLINK_SLOTS < 1) begin : g_param_check
        $error("seg_scan_ctrl: parameter out of range");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    bright_l_q, bright_l_d;
    logic          blank_l_q, blank_l_d;
    logic          wr_ack_q, wr_ack_d;
    logic [4:0]    dbuf_q [NDIG];
    logic [4:0]    dbuf_d [NDIG];

    logic          slot_end;
    logic          blank_eff;
    logic [CW-1:0] on_last, off_last;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

`ifdef SEG_BLINK_EN
    localparam int SW = $clog2(BLINK_SLOTS + 1);

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        phase_d    = phase_q;
        if (slot_end) begin
            if (slot_cnt_q == SW'(BLINK_SLOTS - 1)) begin
                slot_cnt_d = '0;
                phase_d    = ~phase_q;
            end else begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
        end
        blank_eff = blank | (phase_q & blink_mask[idx_q]);
    end

    always_ff @(posedge clk_out100 or negedge nRST) begin
        if (!nRST) begin
            slot_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            phase_q    <= phase_d;
        end
    end
`else
    always_comb blank_eff = blank;
`endif

    // Dwell lengths come from the brightness latched at LOAD, so mid-slot changes wait a slot.
    always_comb begin
        on_last  = CW'((int'(bright_l_q) + 1) * DWELL_UNIT - 1);
        off_last = CW'((7 - int'(bright_l_q)) * DWELL_UNIT - 1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        seg_d      = seg_q;
        bright_l_d = bright_l_q;
        blank_l_d  = blank_l_q;
        slot_end   = 1'b0;

        case (state_q)
            ST_LOAD: begin
                bright_l_d = bright;
                blank_l_d  = blank_eff;
                seg_d      = {dbuf_q[idx_q][4], hex7(dbuf_q[idx_q][3:0])};
                cnt_d      = '0;
                state_d    = ST_ON;
            end
            ST_ON: begin
                if (cnt_q == on_last) begin
                    cnt_d = '0;
                    if (bright_l_q == 3'd7) begin
                        state_d  = ST_LOAD;
                        slot_end = 1'b1;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OFF: begin
                if (cnt_q == off_last) begin
                    cnt_d    = '0;
                    state_d  = ST_LOAD;
                    slot_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (slot_end) begin
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Write port: LOAD reads dbuf_q, so a same-edge write to the loaded entry shows next slot.
    always_comb begin
        wr_ack_d = wr.wr_req & ~wr_ack_q;
        dbuf_d   = dbuf_q;
        if (wr_ack_d && int'(wr.wr_addr) < NDIG) begin
            dbuf_d[wr.wr_addr[IW-1:0]] = wr.wr_data;
        end
    end

    always_ff @(posedge clk_out100 or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            idx_q      <= '0;
            seg_q      <= '0;
            bright_l_q <= '0;
            blank_l_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            dbuf_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            bright_l_q <= bright_l_d;
            blank_l_q  <= blank_l_d;
            wr_ack_q   <= wr_ack_d;
            dbuf_q     <= dbuf_d;
        end
    end

    always_comb begin
        digit_sel = '1;
        if (state_q == ST_ON && !blank_l_q) begin
            digit_sel[idx_q] = 1'b0;
        end
    end

    assign seg       = seg_q;
    assign wr.wr_ack = wr_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-slot expectations from a buffer model go through a scoreboard queue.
module tb_seg_scan_ctrl;

    localparam int NDIG = 6;
    localparam int DW   = 12;
    localparam logic [NDIG-1:0] ALL1 = '1;

    logic            clk_out100 = 1'b0;
    logic            nRST;
    logic [2:0]      bright;
    logic            blank;
    logic [7:0]      seg;
    logic [NDIG-1:0] digit_sel;
`ifdef SEG_BLINK_EN
    logic [NDIG-1:0] blink_mask = '0;
`endif

    always #5 clk_out100 = ~clk_out100;

    seg_scan_ctrl_if wr_if ();

    seg_scan_ctrl #(
        .NDIG        (NDIG),
        .DWELL_UNIT  (DW),
        .BLINK_SLOTS (96)
    ) dut (
        .clk_out100 (clk_out100),
        .nRST       (nRST),
        .wr         (wr_if),
        .bright     (bright),
        .blank      (blank),
`ifdef SEG_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .digit_sel  (digit_sel)
    );

    typedef struct {
        int              idx;
        logic [7:0]      seg;
        logic [NDIG-1:0] dsel_on;
        int              on_len;
    } slot_t;

    slot_t      sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] mbuf [NDIG];
    int         m_idx;
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int         w_total = 0;
    int         w_j;
    int         w_hold;
    logic [2:0] w_addr;
    logic [4:0] w_data;
    logic [7:0] w_got;
    logic [7:0] w_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NDIG; k++) mbuf[k] = 5'h00;
        m_idx = 0;
    endtask

    task automatic start_write(input logic [2:0] addr, input logic [4:0] data, input int hold);
        wr_if.wr_addr = addr;
        wr_if.wr_data = data;
        wr_if.wr_req  = 1'b1;
        w_addr  = addr;
        w_data  = data;
        w_hold  = hold;
        w_total = hold + 1;
        w_j     = 0;
        w_got   = '0;
        w_exp   = '0;
    endtask

    // Called once per sampled cycle; an accepted request shows ack every other cycle while held.
    task automatic service_write();
        if (w_total > 0) begin
            w_got[w_j] = wr_if.wr_ack;
            w_exp[w_j] = (w_j < w_hold) && (w_j % 2 == 0);
            if (w_j == 0 && int'(w_addr) < NDIG) mbuf[w_addr] = w_data;
            w_j++;
            if (w_j == w_hold) wr_if.wr_req = 1'b0;
            if (w_j == w_total) begin
                check($sformatf("wr_ack_pattern_addr%0d", w_addr), 32'(w_got), 32'(w_exp));
                w_total = 0;
            end
        end
    endtask

    task automatic mid_reset();
        #2 nRST = 1'b0;
        #1;
        check("async_rst_dsel", 32'(digit_sel), 32'(ALL1));
        check("async_rst_seg", 32'(seg), 32'h00);
        check("async_rst_ack", 32'(wr_if.wr_ack), 32'h0);
        repeat (3) @(negedge clk_out100);
        check("held_rst_dsel", 32'(digit_sel), 32'(ALL1));
        nRST = 1'b1;
        clear_model();
    endtask

    // One full 97-cycle slot; sample 96 is the LOAD cycle of the following slot.
    task automatic run_slot(input int wr_at, input logic [2:0] wa, input logic [4:0] wd, input int wh,
                            input int chg_at, input logic [2:0] nb, input logic nbl, input int rst_at);
        slot_t           e;
        slot_t           c;
        int              on_seen  = 0;
        int              dsel_err = 0;
        int              seg_err  = 0;
        logic [7:0]      seg0     = '0;
        logic [NDIG-1:0] exp_d;

        e.idx     = m_idx;
        e.seg     = {mbuf[m_idx][4], hex_tab[mbuf[m_idx][3:0]]};
        e.dsel_on = blank ? ALL1 : ~(NDIG'(1) << m_idx);
        e.on_len  = (int'(bright) + 1) * DW;
        sb.push_back(e);

        for (int i = 0; i < 97; i++) begin
            @(negedge clk_out100);
            if (i == 0) begin
                c    = sb.pop_front();
                seg0 = seg;
            end
            if (i == rst_at) begin
                mid_reset();
                return;
            end
            exp_d = (i < c.on_len) ? c.dsel_on : ALL1;
            if (digit_sel !== exp_d) dsel_err++;
            if (i < c.on_len && c.dsel_on !== ALL1 && seg !== c.seg) seg_err++;
            if (digit_sel !== ALL1) on_seen++;
            service_write();
            if (i == wr_at) start_write(wa, wd, wh);
            if (i == chg_at) begin
                bright = nb;
                blank  = nbl;
            end
        end

        check($sformatf("slot_idx%0d_dsel_cycles_wrong", c.idx), 32'(dsel_err), 32'd0);
        check($sformatf("slot_idx%0d_on_cycles", c.idx), 32'(on_seen),
              (c.dsel_on === ALL1) ? 32'd0 : 32'(c.on_len));
        if (c.dsel_on !== ALL1) begin
            check($sformatf("slot_idx%0d_seg", c.idx), 32'(seg0), 32'(c.seg));
            check($sformatf("slot_idx%0d_seg_cycles_wrong", c.idx), 32'(seg_err), 32'd0);
        end
        m_idx = (m_idx + 1) % NDIG;
    endtask

    initial begin
        nRST          = 1'b0;
        bright        = 3'd7;
        blank         = 1'b0;
        wr_if.wr_req  = 1'b0;
        wr_if.wr_addr = '0;
        wr_if.wr_data = '0;
        clear_model();

        repeat (5) begin
            @(negedge clk_out100);
            check("reset_seg", 32'(seg), 32'h00);
            check("reset_dsel", 32'(digit_sel), 32'(ALL1));
            check("reset_ack", 32'(wr_if.wr_ack), 32'h0);
        end
        nRST = 1'b1;

        run_slot(10, 3'd2, 5'h1A, 1, -1, 3'd0, 1'b0, -1);   // idx0, write digit 2
        run_slot(20, 3'd3, 5'h05, 4, 60, 3'd0, 1'b0, -1);   // idx1, held request, bright->0
        run_slot(-1, 3'd0, 5'h00, 0, 50, 3'd3, 1'b0, -1);   // idx2 shows F7, bright->3
        run_slot(96, 3'd4, 5'h1F, 1, -1, 3'd0, 1'b0, -1);   // idx3, write lands on LOAD of idx4
        run_slot(-1, 3'd0, 5'h00, 0, 30, 3'd3, 1'b1, -1);   // idx4 keeps old value, blank on
        run_slot(40, 3'd7, 5'h08, 1, 30, 3'd3, 1'b0, -1);   // idx5 blanked, out-of-range write

        run_slot(-1, 3'd0, 5'h00, 0, 10, 3'd7, 1'b0, -1);
        for (int s = 1; s < NDIG; s++) run_slot(-1, 3'd0, 5'h00, 0, -1, 3'd0, 1'b0, -1);

        for (int s = 0; s < 3; s++) run_slot(-1, 3'd0, 5'h00, 0, -1, 3'd0, 1'b0, -1);
        run_slot(-1, 3'd0, 5'h00, 0, -1, 3'd0, 1'b0, 20);   // reset during ON of idx3

        for (int s = 0; s < 4; s++) run_slot(-1, 3'd0, 5'h00, 0, -1, 3'd0, 1'b0, -1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NDIG, default 6, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter DWELL_UNIT, default 12, clk_out100 cycles per brightness step.
REQ-003 Parameter BLINK_SLOTS, default 96, scan slots per blink half-period; used only with SEG_BLINK_EN.
REQ-004 clk_out100  in  1  block clock; all logic on its rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 wr_req  in  1  host write request; held high until wr_ack.
REQ-007 wr_addr  in  3  digit index to write.
REQ-008 wr_data  in  5  bit4 is the decimal point; bits 3:0 are the hex nibble.
REQ-009 wr_ack  out  1  one-cycle write acknowledge.
REQ-010 bright  in  3  brightness level 0..7.
REQ-011 blank  in  1  global blank; 1 forces all digits off.
REQ-012 seg  out  8  active-high segments; bit7 = dp, bits 6:0 = g..a.
REQ-013 digit_sel  out  NDIG  active-low one-hot digit enable.

Function
REQ-014 The buffer SHALL hold NDIG 5-bit entries; the FSM SHALL have states LOAD, ON and OFF, and the digit index idx SHALL cycle 0..NDIG-1.
REQ-015 LOAD SHALL last 1 cycle and drive digit_sel all-ones; it SHALL latch buf[idx], bright and blank, and SHALL register the decoded seg value.
REQ-016 ON SHALL last (bright+1)*DWELL_UNIT cycles and drive digit_sel with bit idx low, unless the latched blank is 1, in which case digit_sel SHALL be all-ones.
REQ-017 OFF SHALL last (7-bright)*DWELL_UNIT cycles with digit_sel all-ones; when bright=7, ON SHALL go directly to LOAD.
REQ-018 The slot length SHALL be 1+8*DWELL_UNIT cycles (97 at default) regardless of brightness; idx SHALL increment on leaving the slot and wrap from NDIG-1 to 0.
REQ-019 The hex decode SHALL be, for nibbles 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71; seg[7] SHALL equal the latched dp bit.
REQ-020 When wr_req=1 and wr_ack=0, the next edge SHALL set wr_ack=1 for exactly one cycle; on that same edge buf[wr_addr] SHALL be written if wr_addr<NDIG.
REQ-021 If wr_addr>=NDIG, the block SHALL still acknowledge the request and SHALL leave the buffer unchanged.
REQ-022 A request still held high after its ack SHALL be accepted again 2 cycles after the previous acceptance.
REQ-023 If a write and a LOAD target the same entry on the same edge, LOAD SHALL capture the old value; the new value SHALL appear at that digit's next slot.
REQ-024 Changes to bright or blank in the middle of a slot SHALL take effect only at the next LOAD.

Reset
REQ-025 While nRST=0, outputs SHALL be held at seg=8'h00, digit_sel all-ones and wr_ack=0, and state SHALL be LOAD, idx=0, counters 0 and buffer entries all 5'h00.
REQ-026 Reset assertion SHALL take effect immediately at any point in operation; after release, the first rising edge SHALL execute LOAD for idx 0.

Configuration
REQ-027 With macro SEG_BLINK_EN defined, the block SHALL add input blink_mask[NDIG-1:0] and a slot counter that toggles a blink phase every BLINK_SLOTS slots; during phase 1, digits whose mask bit is set SHALL be forced off, as if blank were set.
REQ-028 Without SEG_BLINK_EN, the block SHALL have no blink_mask port and no blink counter, and its behaviour SHALL be exactly REQ-014..REQ-026.

Verification
REQ-029 Reset scenario: nRST low for 5 cycles -> seg=00 and digit_sel=3F during reset; after release, slot 0 shows seg=3F and digit_sel=111110 for 96 cycles with bright=7.
REQ-030 Write scenario: wr_addr=2, wr_data=5'h1A -> wr_ack pulses 1 cycle after the request; slot 2 then shows seg=F7 and digit_sel=111011.
REQ-031 Brightness scenario: bright=0 -> ON 12 cycles and OFF 84; bright=3 -> ON 48 and OFF 48; slot length stays 97 in every case.
REQ-032 Out-of-range write: wr_addr=7 -> wr_ack pulses; all six digits show their previous values.
REQ-033 Mid-operation reset: nRST pulled low during ON of idx 3 -> digit_sel=3F and seg=00 without waiting for a clock edge; restart from idx 0 with the buffer cleared.
REQ-034 Blink scenario: with SEG_BLINK_EN, blink_mask=000001 -> digit 0 is dark for 96 slots and lit for the next 96, while other digits are unaffected.
